// File: rtl/result_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_bcd_converter                                                     |
// | Sequential double-dabble binary-to-BCD converter with blanking mask.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module result_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int c_CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_shift;
  logic [4*DIGITS-1:0]   r_scratch;
  logic [c_CW-1:0]       r_cnt;

  logic [4*DIGITS-1:0]   w_corrected;
  logic [4*DIGITS-1:0]   w_next_scratch;
  logic [DIGITS-1:0]     w_en;
  logic                  w_nz;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_corrected[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                   (r_scratch[4*g +: 4] + 4'd3) :
                                   r_scratch[4*g +: 4];
  end

  assign w_next_scratch = {w_corrected[4*DIGITS-2:0], r_shift[WIDTH-1]};

  // A digit is shown once it or any more significant digit is nonzero.
  always_comb begin
    w_nz = 1'b0;
    w_en = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nz    = w_nz | (w_next_scratch[4*i +: 4] != 4'd0);
      w_en[i] = w_nz;
    end
    w_en[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      digit_en  <= DIGITS'(1);
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= bin_in;
            r_scratch <= '0;
            r_cnt     <= c_CW'(WIDTH);
            busy      <= 1'b1;
            r_state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_scratch <= w_next_scratch;
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt - c_CW'(1);
          if (r_cnt == c_CW'(1)) begin
            bcd_out  <= w_next_scratch;
            digit_en <= w_en;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_result_bcd_converter                                                  |
// | Directed and sweep checks of result_bcd_converter (WIDTH=8, DIGITS=3).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_result_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [2:0]  digit_en;

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt = 0;
  int dbl_done = 0;
  logic prev_done = 1'b0;

  result_bcd_converter #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .digit_en (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && prev_done) dbl_done++;
    prev_done = done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic launch(input logic [7:0] v);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = ~v;
  endtask

  // Counts edges until done is seen; flags any bcd_out change or busy drop on the way.
  task automatic wait_done(output int lat, output logic held, output logic busy_ok);
    logic [11:0] entry;
    entry   = bcd_out;
    lat     = -1;
    held    = 1'b1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (bcd_out !== entry) held = 1'b0;
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [2:0] ref_en(input int v);
    if (v >= 100) return 3'b111;
    if (v >= 10)  return 3'b011;
    return 3'b001;
  endfunction

  logic [7:0]  dir_v   [5] = '{8'd0, 8'd9, 8'd42, 8'd100, 8'd255};
  logic [11:0] dir_bcd [5] = '{12'h000, 12'h009, 12'h042, 12'h100, 12'h255};
  logic [2:0]  dir_en  [5] = '{3'b001, 3'b001, 3'b011, 3'b111, 3'b111};

  initial begin
    int   lat;
    logic held, bok;
    int   d0, starts;

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_bcd", bcd_out, 12'h000);
    check_eq("rst_en", digit_en, 3'b001);

    d0 = done_cnt;
    repeat (20) begin @(posedge clk); #1; end
    check_eq("idle_bcd", bcd_out, 12'h000);
    check_eq("idle_en", digit_en, 3'b001);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_nodone", done_cnt - d0, 0);

    for (int i = 0; i < 5; i++) begin
      launch(dir_v[i]);
      check_eq("dir_busy1", busy, 1);
      wait_done(lat, held, bok);
      check_eq("dir_lat", lat, 8);
      check_eq("dir_bcd", bcd_out, dir_bcd[i]);
      check_eq("dir_en", digit_en, dir_en[i]);
      check_eq("dir_busyseq", bok, 1);
      @(posedge clk); #1;
      check_eq("dir_donepulse", done, 0);
    end

    // Starts during a conversion are ignored; bin_in wiggles.
    d0 = done_cnt;
    launch(8'd200);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      start  = (k == 2 || k == 4);
      bin_in = 8'd7;
    end
    start = 1'b0;
    check_eq("ign_lat", lat, 8);
    check_eq("ign_bcd", bcd_out, 12'h200);
    check_eq("ign_en", digit_en, 3'b111);
    repeat (12) begin @(posedge clk); #1; end
    check_eq("ign_ndone", done_cnt - d0, 1);
    check_eq("ign_idle", busy, 0);

    // Reset mid-conversion.
    launch(8'd123);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_bcd", bcd_out, 12'h000);
    check_eq("abort_en", digit_en, 3'b001);
    d0 = done_cnt;
    repeat (20) begin @(posedge clk); #1; end
    check_eq("abort_nodone", done_cnt - d0, 0);

    // Back-to-back: restart in the done cycle.
    launch(8'd58);
    wait_done(lat, held, bok);
    check_eq("b2b_lat1", lat, 8);
    check_eq("b2b_bcd1", bcd_out, 12'h058);
    check_eq("b2b_en1", digit_en, 3'b011);
    launch(8'd61);
    check_eq("b2b_busy", busy, 1);
    wait_done(lat, held, bok);
    check_eq("b2b_lat2", lat + 1, 9);
    check_eq("b2b_hold", held, 1);
    check_eq("b2b_bcd2", bcd_out, 12'h061);
    check_eq("b2b_en2", digit_en, 3'b011);

    // Full sweep with random idle gaps.
    repeat (2) begin @(posedge clk); #1; end
    d0 = done_cnt;
    starts = 0;
    for (int v = 0; v < 256; v++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      launch(8'(v));
      starts++;
      wait_done(lat, held, bok);
      check_eq($sformatf("sw_lat_%0d", v), lat, 8);
      check_eq($sformatf("sw_bcd_%0d", v), bcd_out, ref_bcd(v));
      check_eq($sformatf("sw_en_%0d", v), digit_en, ref_en(v));
    end
    repeat (3) begin @(posedge clk); #1; end
    check_eq("sw_ndone", done_cnt - d0, starts);
    check_eq("dbl_done", dbl_done, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
